// File: rtl/arb_pkg.sv
// Shared types and constants for the three-requester priority/round-robin arbiter.
package arb_pkg;

    localparam int unsigned NREQ = 3;
    localparam int unsigned ID_W = 2;
    localparam int unsigned PTR_W = 2;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT   = 2'd1,
        RELEASE = 2'd2
    } arb_state_e;

    localparam logic [ID_W-1:0] GID_NONE = 2'b00;
    localparam logic [ID_W-1:0] GID_R0   = 2'b01;
    localparam logic [ID_W-1:0] GID_R1   = 2'b10;
    localparam logic [ID_W-1:0] GID_R2   = 2'b11;

    // Encode a one-hot grant into the datapath mux code.
    function automatic logic [ID_W-1:0] grant_to_id(input logic [NREQ-1:0] g);
        if (g[2])      return GID_R2;
        else if (g[1]) return GID_R1;
        else if (g[0]) return GID_R0;
        else           return GID_NONE;
    endfunction

    // Index of a one-hot winner, used as the round-robin pointer.
    function automatic logic [PTR_W-1:0] onehot_to_idx(input logic [NREQ-1:0] g);
        if (g[2])      return 2'd2;
        else if (g[1]) return 2'd1;
        else           return 2'd0;
    endfunction

endpackage

// File: rtl/arb_pick.sv
// Combinational winner selection: fixed priority (2>1>0) or round-robin after last.
module arb_pick
    import arb_pkg::*;
(
    input  logic [NREQ-1:0]  eligible,
    input  logic             mode,
    input  logic [PTR_W-1:0] last,
    output logic [NREQ-1:0]  winner,
    output logic             valid
);

    always_comb begin
        winner = '0;
        if (!mode) begin
            if (eligible[2])      winner = 3'b100;
            else if (eligible[1]) winner = 3'b010;
            else if (eligible[0]) winner = 3'b001;
        end else begin
            // Search upward starting just after the previous owner.
            unique case (last)
                2'd0: begin
                    if (eligible[1])      winner = 3'b010;
                    else if (eligible[2]) winner = 3'b100;
                    else if (eligible[0]) winner = 3'b001;
                end
                2'd1: begin
                    if (eligible[2])      winner = 3'b100;
                    else if (eligible[0]) winner = 3'b001;
                    else if (eligible[1]) winner = 3'b010;
                end
                default: begin
                    if (eligible[0])      winner = 3'b001;
                    else if (eligible[1]) winner = 3'b010;
                    else if (eligible[2]) winner = 3'b100;
                end
            endcase
        end
    end

    assign valid = |winner;

endmodule

// File: rtl/priority_grant_arbiter.sv
// Three-requester arbiter: grant held until done, request drop or hold limit,
// with a one-cycle dead gap between grants and one-shot masking after timeout.
module priority_grant_arbiter
    import arb_pkg::*;
#(
    parameter  int unsigned MAX_HOLD = 16,
    localparam int unsigned CNT_W    = $clog2(MAX_HOLD + 1)
) (
    input  logic            clk_i,
    input  logic            rst_n_i,
    input  logic [NREQ-1:0] req_i,
    input  logic            done_i,
    input  logic            mode_i,
    output logic [NREQ-1:0] grant_o,
    output logic [ID_W-1:0] grant_id_o,
    output logic            busy_o,
    output logic            timeout_o
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_HOLD - 1);

    arb_state_e       state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic [PTR_W-1:0] last, last_nxt;
    logic [NREQ-1:0]  mask, mask_nxt;
    logic [NREQ-1:0]  grant_nxt;
    logic             timeout_nxt;
    logic [NREQ-1:0]  unmasked, eligible, winner;
    logic             win_valid;
    logic             owner_req, hold_exp;

    // A masked requester that is the only one asking is not locked out.
    assign unmasked = req_i & ~mask;
    assign eligible = (unmasked != '0) ? unmasked : req_i;

    arb_pick u_pick (
        .eligible (eligible),
        .mode     (mode_i),
        .last     (last),
        .winner   (winner),
        .valid    (win_valid)
    );

    assign owner_req = |(req_i & grant_o);
    assign hold_exp  = (cnt == CNT_LAST);

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state      <= IDLE;
            cnt        <= '0;
            last       <= 2'd2;
            mask       <= '0;
            grant_o    <= '0;
            grant_id_o <= GID_NONE;
            busy_o     <= 1'b0;
            timeout_o  <= 1'b0;
        end else begin
            state      <= state_nxt;
            cnt        <= cnt_nxt;
            last       <= last_nxt;
            mask       <= mask_nxt;
            grant_o    <= grant_nxt;
            grant_id_o <= grant_to_id(grant_nxt);
            busy_o     <= |grant_nxt;
            timeout_o  <= timeout_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        cnt_nxt     = cnt;
        last_nxt    = last;
        mask_nxt    = mask;
        grant_nxt   = grant_o;
        timeout_nxt = 1'b0;
        unique case (state)
            IDLE, RELEASE: begin
                // Arbitration point: the mask applies to this decision only.
                mask_nxt  = '0;
                cnt_nxt   = '0;
                grant_nxt = winner;
                if (win_valid) begin
                    state_nxt = GRANT;
                    last_nxt  = onehot_to_idx(winner);
                end else begin
                    state_nxt = IDLE;
                end
            end
            GRANT: begin
                if (done_i || !owner_req || hold_exp) begin
                    state_nxt = RELEASE;
                    grant_nxt = '0;
                    // Only a pure hold-limit expiry counts as a forced release.
                    if (hold_exp && !done_i && owner_req) begin
                        timeout_nxt = 1'b1;
                        mask_nxt    = grant_o;
                    end
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
            default: begin
                state_nxt = IDLE;
                grant_nxt = '0;
            end
        endcase
    end

endmodule
